// File: rtl/cart_pkg.sv
// cart_pkg: shared encodings for the cartridge bank-switching unit.
// Holds mapper mode codes, ROM size codes, hotspot base addresses and
// the auto-mode resolver used by cart_mapper.
package cart_pkg;

   typedef enum logic [2:0] {
      MODE_NONE = 3'd0,
      MODE_F8   = 3'd1,
      MODE_F6   = 3'd2,
      MODE_F4   = 3'd3,
      MODE_FE   = 3'd4,
      MODE_E0   = 3'd5,
      MODE_3F   = 3'd6,
      MODE_AUTO = 3'd7
   } mode_t;

   typedef enum logic {
      FE_IDLE  = 1'b0,
      FE_ARMED = 1'b1
   } fe_state_t;

   localparam logic [2:0] SIZE_4K  = 3'b000;
   localparam logic [2:0] SIZE_8K  = 3'b001;
   localparam logic [2:0] SIZE_16K = 3'b011;
   localparam logic [2:0] SIZE_32K = 3'b111;

   localparam logic [12:0] HS_F8 = 13'h1FF8;
   localparam logic [12:0] HS_F6 = 13'h1FF6;
   localparam logic [12:0] HS_F4 = 13'h1FF4;
   localparam logic [12:0] HS_E0 = 13'h1FE0;
   localparam logic [12:0] HS_FE = 13'h01FE;

   // Auto mode picks the classic F-scheme matching the loaded image size;
   // sizes that are not a clean power of two fall back to no mapping.
   function automatic mode_t resolve_mode(input logic [2:0] mode, input logic [2:0] size);
      mode_t m;
      m = mode_t'(mode);
      if (m == MODE_AUTO) begin
         case (size)
            SIZE_8K:  m = MODE_F8;
            SIZE_16K: m = MODE_F6;
            SIZE_32K: m = MODE_F4;
            default:  m = MODE_NONE;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/cart_mapper_if.sv
// cart_mapper_if: CPU bus, loader snoop and cartridge memory selects.
// Handshake: there is no valid/ready pair; bus_strobe_i is a one-clock
// qualifier marking the single clock per CPU cycle on which address and
// data are stable, and all bank state changes only on such clocks.
interface cart_mapper_if #(
   parameter int ROM_ADDR_BITS = 15,
   parameter int SC_RAM_BITS   = 7
);
   import cart_pkg::*;

   logic                     bus_strobe_i;
   logic [12:0]              cpu_addr_i;
   logic                     cpu_we_i;
   logic [7:0]               bus_data_i;
   logic [2:0]               mode_i;
   logic                     sc_en_i;
   logic                     load_we_i;
   logic [ROM_ADDR_BITS-1:0] load_addr_i;
   logic [ROM_ADDR_BITS-1:0] rom_addr_o;
   logic                     rom_cs_o;
   logic [SC_RAM_BITS-1:0]   sc_addr_o;
   logic                     sc_rd_o;
   logic                     sc_we_o;
   logic [2:0]               rom_size_o;
   logic [7:0]               bank_o;
   fe_state_t                dbg_fe_state_o;

   modport master (
      output bus_strobe_i, cpu_addr_i, cpu_we_i, bus_data_i, mode_i, sc_en_i,
             load_we_i, load_addr_i,
      input  rom_addr_o, rom_cs_o, sc_addr_o, sc_rd_o, sc_we_o, rom_size_o,
             bank_o, dbg_fe_state_o
   );

   modport slave (
      input  bus_strobe_i, cpu_addr_i, cpu_we_i, bus_data_i, mode_i, sc_en_i,
             load_we_i, load_addr_i,
      output rom_addr_o, rom_cs_o, sc_addr_o, sc_rd_o, sc_we_o, rom_size_o,
             bank_o, dbg_fe_state_o
   );

endinterface

// File: rtl/cart_size_detect.sv
// cart_size_detect: snoops the SPI ROM loader and records which 4K/8K/16K
// boundaries the image crosses, giving a thermometer-style size code.
module cart_size_detect
   import cart_pkg::*;
#(
   parameter int ROM_ADDR_BITS = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     i_load_we,
   input  logic [ROM_ADDR_BITS-1:0] i_load_addr,
   output logic [2:0]               o_rom_size
);

   logic [14:0] w_addr;
   logic [2:0]  r_size;

   assign w_addr = 15'(i_load_addr);

   // A write to a 16K-aligned start clears the code; other writes OR in bits 14:12.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_size <= SIZE_4K;
      end else if (i_load_we) begin
         if (w_addr[13:0] == 14'd0) r_size <= SIZE_4K;
         else                       r_size <= r_size | {w_addr[14], w_addr[13], w_addr[12]};
      end
   end

   assign o_rom_size = r_size;

endmodule

// File: rtl/cart_mapper.sv
// cart_mapper: Atari 2600 cartridge bank switching (F8/F6/F4/FE/E0/3F/auto)
// with SuperChip RAM decode. Banks advance on bus_strobe_i; ROM address
// and selects are combinational from the CPU address and the bank registers.
module cart_mapper
   import cart_pkg::*;
#(
   parameter int ROM_ADDR_BITS = 15,
   parameter int SC_RAM_BITS   = 7
) (
   input logic          clk_i,
   input logic          rst_i,
   cart_mapper_if.slave bus
);

   localparam int         B3F_W    = ROM_ADDR_BITS - 11;
   localparam logic [7:0] B3F_MASK = 8'((1 << B3F_W) - 1);

   mode_t                    w_mode;
   mode_t                    r_mode;
   fe_state_t                r_fe_state;
   logic [2:0]               r_bank;
   logic [2:0]               r_e0_s0, r_e0_s1, r_e0_s2;
   logic [7:0]               r_bank_3f;
   logic [2:0]               w_rom_size;
   logic [12:0]              w_addr;
   logic                     w_hit_f8, w_hit_f6, w_hit_f4, w_hit_e0;
   logic [2:0]               w_slice_bank;
   logic [7:0]               w_bank_3f;
   logic [ROM_ADDR_BITS-1:0] w_rom_addr;
   logic [7:0]               w_bank_dbg;
   logic                     w_sc_active, w_sc_wr_port, w_sc_rd_port;

   cart_size_detect #(.ROM_ADDR_BITS(ROM_ADDR_BITS)) u_size (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_load_we   (bus.load_we_i),
      .i_load_addr (bus.load_addr_i),
      .o_rom_size  (w_rom_size)
   );

   assign w_addr   = bus.cpu_addr_i;
   assign w_mode   = resolve_mode(bus.mode_i, w_rom_size);
   assign w_hit_f8 = (w_addr >= HS_F8) && (w_addr <= HS_F8 + 13'd1);
   assign w_hit_f6 = (w_addr >= HS_F6) && (w_addr <= HS_F6 + 13'd3);
   assign w_hit_f4 = (w_addr >= HS_F4) && (w_addr <= HS_F4 + 13'd7);
   assign w_hit_e0 = (w_addr[12:5] == HS_E0[12:5]);

   // Bank registers and FE FSM; a change of effective mode restores reset banks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mode     <= MODE_NONE;
         r_fe_state <= FE_IDLE;
         r_bank     <= 3'd0;
         r_e0_s0    <= 3'd0;
         r_e0_s1    <= 3'd1;
         r_e0_s2    <= 3'd2;
         r_bank_3f  <= 8'd0;
      end else if (w_mode != r_mode) begin
         r_mode     <= w_mode;
         r_fe_state <= FE_IDLE;
         r_bank     <= 3'd0;
         r_e0_s0    <= 3'd0;
         r_e0_s1    <= 3'd1;
         r_e0_s2    <= 3'd2;
         r_bank_3f  <= 8'd0;
      end else if (bus.bus_strobe_i) begin
         case (r_mode)
            MODE_F8: if (w_hit_f8) r_bank <= 3'(w_addr - HS_F8);
            MODE_F6: if (w_hit_f6) r_bank <= 3'(w_addr - HS_F6);
            MODE_F4: if (w_hit_f4) r_bank <= 3'(w_addr - HS_F4);
            MODE_FE: begin
               // The access after 01FE carries the bank in data bit 5 (inverted).
               if (r_fe_state == FE_ARMED) begin
                  r_bank     <= {2'd0, ~bus.bus_data_i[5]};
                  r_fe_state <= (w_addr == HS_FE) ? FE_ARMED : FE_IDLE;
               end else if (w_addr == HS_FE) begin
                  r_fe_state <= FE_ARMED;
               end
            end
            MODE_E0: begin
               if (w_hit_e0) begin
                  case (w_addr[4:3])
                     2'd0:    r_e0_s0 <= w_addr[2:0];
                     2'd1:    r_e0_s1 <= w_addr[2:0];
                     2'd2:    r_e0_s2 <= w_addr[2:0];
                     default: ;
                  endcase
               end
            end
            MODE_3F: begin
               if (bus.cpu_we_i && !w_addr[12] && (w_addr[7:6] == 2'b00))
                  r_bank_3f <= bus.bus_data_i & B3F_MASK;
            end
            default: ;
         endcase
      end
   end

   // ROM address composition per scheme plus the diagnostic bank view.
   always_comb begin
      case (w_addr[11:10])
         2'd0:    w_slice_bank = r_e0_s0;
         2'd1:    w_slice_bank = r_e0_s1;
         2'd2:    w_slice_bank = r_e0_s2;
         default: w_slice_bank = 3'd7;
      endcase
      w_bank_3f  = w_addr[11] ? B3F_MASK : r_bank_3f;
      w_rom_addr = ROM_ADDR_BITS'(w_addr[11:0]);
      w_bank_dbg = {5'd0, r_bank};
      case (w_mode)
         MODE_F8, MODE_F6, MODE_F4, MODE_FE:
            w_rom_addr = ROM_ADDR_BITS'({r_bank, w_addr[11:0]});
         MODE_E0: begin
            w_rom_addr = ROM_ADDR_BITS'({w_slice_bank, w_addr[9:0]});
            w_bank_dbg = {5'd0, r_e0_s0};
         end
         MODE_3F: begin
            w_rom_addr = ROM_ADDR_BITS'({w_bank_3f, w_addr[10:0]});
            w_bank_dbg = r_bank_3f;
         end
         default: ;
      endcase
   end

   // SuperChip: 1000-107F write port, 1080-10FF read port; both hide the ROM.
   assign w_sc_active  = bus.sc_en_i && (w_mode != MODE_3F) && (w_mode != MODE_E0);
   assign w_sc_wr_port = (w_addr[12:7] == 6'b100000);
   assign w_sc_rd_port = (w_addr[12:7] == 6'b100001);

   assign bus.rom_addr_o     = w_rom_addr;
   assign bus.rom_cs_o       = w_addr[12] && !(w_sc_active && (w_sc_wr_port || w_sc_rd_port));
   assign bus.sc_addr_o      = w_addr[SC_RAM_BITS-1:0];
   assign bus.sc_rd_o        = w_sc_active && w_sc_rd_port;
   assign bus.sc_we_o        = w_sc_active && w_sc_wr_port && bus.cpu_we_i && bus.bus_strobe_i;
   assign bus.rom_size_o     = w_rom_size;
   assign bus.bank_o         = w_bank_dbg;
   assign bus.dbg_fe_state_o = r_fe_state;

endmodule

// File: tb/tb_cart_mapper.sv
// tb_cart_mapper: directed vector table plus hand-written multi-cycle
// sequences (auto size detection, concurrent load/hotspot, async reset).
module tb_cart_mapper;
   import cart_pkg::*;

   localparam int RAB = 15;
   localparam int SCB = 7;

   typedef struct {
      logic [2:0]     mode;
      logic           sc_en;
      logic [12:0]    addr;
      logic           we;
      logic [7:0]     data;
      logic           stb;
      logic [RAB-1:0] exp_rom;
      logic           exp_cs;
      logic [7:0]     exp_bank;
      logic           exp_rd;
      logic           exp_we;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   cart_mapper_if #(.ROM_ADDR_BITS(RAB), .SC_RAM_BITS(SCB)) bus ();

   cart_mapper #(.ROM_ADDR_BITS(RAB), .SC_RAM_BITS(SCB)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // clock
   always #5 clk = ~clk;

   function automatic void v(input logic [2:0] m, input logic sc, input logic [12:0] a,
                             input logic we, input logic [7:0] d, input logic stb,
                             input logic [RAB-1:0] er, input logic ec, input logic [7:0] eb,
                             input logic erd, input logic ewe);
      vec_t t;
      t.mode = m; t.sc_en = sc; t.addr = a; t.we = we; t.data = d; t.stb = stb;
      t.exp_rom = er; t.exp_cs = ec; t.exp_bank = eb; t.exp_rd = erd; t.exp_we = ewe;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change just after a falling edge; outputs are read at the next falling edge.
   task automatic drive(input logic [2:0] m, input logic sc, input logic [12:0] a,
                        input logic we, input logic [7:0] d, input logic stb);
      bus.mode_i       = m;
      bus.sc_en_i      = sc;
      bus.cpu_addr_i   = a;
      bus.cpu_we_i     = we;
      bus.bus_data_i   = d;
      bus.bus_strobe_i = stb;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [RAB-1:0] a);
      bus.load_we_i   = 1'b1;
      bus.load_addr_i = a;
      @(posedge clk);
      @(negedge clk);
      bus.load_we_i   = 1'b0;
   endtask

   initial begin
      // reset
      rst = 1'b1;
      bus.bus_strobe_i = 1'b0; bus.cpu_addr_i = 13'h1234; bus.cpu_we_i = 1'b0;
      bus.bus_data_i = 8'h00; bus.mode_i = 3'd0; bus.sc_en_i = 1'b0;
      bus.load_we_i = 1'b0; bus.load_addr_i = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_size", 32'(bus.rom_size_o), 32'h0);
      chk("reset_bank", 32'(bus.bank_o), 32'h0);
      chk("reset_sc_we", 32'(bus.sc_we_o), 32'h0);

      //   mode sc addr     we data   stb  rom      cs bank   rd we
      v(0, 0, 13'h1234, 0, 8'h00, 0, 15'h0234, 1, 8'h00, 0, 0);
      v(0, 0, 13'h1FF8, 0, 8'h00, 1, 15'h0FF8, 1, 8'h00, 0, 0);
      v(3, 0, 13'h1234, 0, 8'h00, 0, 15'h0234, 1, 8'h00, 0, 0);
      v(3, 0, 13'h1FF7, 0, 8'h00, 1, 15'h3FF7, 1, 8'h03, 0, 0);
      v(3, 0, 13'h1234, 0, 8'h00, 0, 15'h3234, 1, 8'h03, 0, 0);
      v(3, 0, 13'h1FFB, 0, 8'h00, 1, 15'h7FFB, 1, 8'h07, 0, 0);
      v(3, 0, 13'h1234, 0, 8'h00, 0, 15'h7234, 1, 8'h07, 0, 0);
      v(3, 0, 13'h1FF3, 0, 8'h00, 1, 15'h7FF3, 1, 8'h07, 0, 0);
      v(3, 0, 13'h1FFC, 1, 8'h00, 1, 15'h7FFC, 1, 8'h07, 0, 0);
      v(1, 0, 13'h1000, 0, 8'h00, 0, 15'h0000, 1, 8'h00, 0, 0);
      v(1, 0, 13'h1FF9, 0, 8'h00, 1, 15'h1FF9, 1, 8'h01, 0, 0);
      v(1, 0, 13'h1FF7, 0, 8'h00, 1, 15'h1FF7, 1, 8'h01, 0, 0);
      v(1, 0, 13'h1FF8, 1, 8'hAA, 1, 15'h0FF8, 1, 8'h00, 0, 0);
      v(2, 0, 13'h1000, 0, 8'h00, 0, 15'h0000, 1, 8'h00, 0, 0);
      v(2, 0, 13'h1FF9, 0, 8'h00, 1, 15'h3FF9, 1, 8'h03, 0, 0);
      v(2, 0, 13'h1FF6, 0, 8'h00, 1, 15'h0FF6, 1, 8'h00, 0, 0);
      v(2, 0, 13'h1FF8, 0, 8'h00, 1, 15'h2FF8, 1, 8'h02, 0, 0);
      v(0, 0, 13'h1FF8, 0, 8'h00, 0, 15'h0FF8, 1, 8'h00, 0, 0);
      v(5, 0, 13'h1000, 0, 8'h00, 0, 15'h0000, 1, 8'h00, 0, 0);
      v(5, 0, 13'h1FE5, 0, 8'h00, 1, 15'h1FE5, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1FEA, 0, 8'h00, 1, 15'h1FEA, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1FF1, 0, 8'h00, 1, 15'h1FF1, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1000, 0, 8'h00, 0, 15'h1400, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1400, 0, 8'h00, 0, 15'h0800, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1800, 0, 8'h00, 0, 15'h0400, 1, 8'h05, 0, 0);
      v(5, 0, 13'h1C00, 0, 8'h00, 0, 15'h1C00, 1, 8'h05, 0, 0);
      v(5, 1, 13'h1005, 1, 8'h00, 1, 15'h1405, 1, 8'h05, 0, 0);
      v(5, 1, 13'h1085, 0, 8'h00, 0, 15'h1485, 1, 8'h05, 0, 0);
      v(6, 0, 13'h1100, 0, 8'h00, 0, 15'h0100, 1, 8'h00, 0, 0);
      v(6, 0, 13'h003F, 1, 8'h0B, 1, 15'h583F, 0, 8'h0B, 0, 0);
      v(6, 0, 13'h1100, 0, 8'h00, 0, 15'h5900, 1, 8'h0B, 0, 0);
      v(6, 0, 13'h1900, 0, 8'h00, 0, 15'h7900, 1, 8'h0B, 0, 0);
      v(6, 0, 13'h0080, 1, 8'h03, 1, 15'h5880, 0, 8'h0B, 0, 0);
      v(6, 0, 13'h003F, 0, 8'h02, 1, 15'h583F, 0, 8'h0B, 0, 0);
      v(6, 0, 13'h0000, 1, 8'hF3, 1, 15'h1800, 0, 8'h03, 0, 0);
      v(6, 1, 13'h1005, 1, 8'h00, 1, 15'h1805, 1, 8'h03, 0, 0);
      v(5, 0, 13'h1400, 0, 8'h00, 0, 15'h0400, 1, 8'h00, 0, 0);
      v(5, 0, 13'h1800, 0, 8'h00, 0, 15'h0800, 1, 8'h00, 0, 0);
      v(1, 1, 13'h1000, 0, 8'h00, 0, 15'h0000, 0, 8'h00, 0, 0);
      v(1, 1, 13'h1005, 1, 8'h5A, 1, 15'h0005, 0, 8'h00, 0, 1);
      v(1, 1, 13'h1005, 1, 8'h5A, 0, 15'h0005, 0, 8'h00, 0, 0);
      v(1, 1, 13'h1085, 0, 8'h00, 1, 15'h0085, 0, 8'h00, 1, 0);
      v(1, 1, 13'h1100, 0, 8'h00, 0, 15'h0100, 1, 8'h00, 0, 0);
      v(1, 0, 13'h1085, 0, 8'h00, 0, 15'h0085, 1, 8'h00, 0, 0);
      v(1, 1, 13'h1FF9, 0, 8'h00, 1, 15'h1FF9, 1, 8'h01, 0, 0);
      v(4, 0, 13'h1000, 0, 8'h00, 0, 15'h0000, 1, 8'h00, 0, 0);
      v(4, 0, 13'h01FE, 0, 8'h00, 1, 15'h01FE, 0, 8'h00, 0, 0);
      v(4, 0, 13'h1000, 0, 8'h00, 0, 15'h0000, 1, 8'h00, 0, 0);
      v(4, 0, 13'h1234, 0, 8'h00, 1, 15'h1234, 1, 8'h01, 0, 0);
      v(4, 0, 13'h1234, 0, 8'h20, 1, 15'h1234, 1, 8'h01, 0, 0);
      v(4, 0, 13'h01FE, 0, 8'h00, 1, 15'h11FE, 0, 8'h01, 0, 0);
      v(4, 0, 13'h1000, 0, 8'h20, 1, 15'h0000, 1, 8'h00, 0, 0);
      v(4, 0, 13'h01FE, 0, 8'h00, 1, 15'h01FE, 0, 8'h00, 0, 0);
      v(4, 0, 13'h01FE, 0, 8'h00, 1, 15'h11FE, 0, 8'h01, 0, 0);
      v(4, 0, 13'h1000, 0, 8'h20, 1, 15'h0000, 1, 8'h00, 0, 0);
      v(4, 0, 13'h1000, 0, 8'h00, 1, 15'h0000, 1, 8'h00, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].mode, vecs[i].sc_en, vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].stb);
         n_vec++;
         if ({bus.rom_addr_o, bus.rom_cs_o, bus.bank_o, bus.sc_rd_o, bus.sc_we_o} !==
             {vecs[i].exp_rom, vecs[i].exp_cs, vecs[i].exp_bank, vecs[i].exp_rd, vecs[i].exp_we}) begin
            n_bad++;
            $display("FAIL vec%0d addr=%h: got rom=%h cs=%b bank=%h rd=%b we=%b expected rom=%h cs=%b bank=%h rd=%b we=%b",
                     i, vecs[i].addr, bus.rom_addr_o, bus.rom_cs_o, bus.bank_o, bus.sc_rd_o, bus.sc_we_o,
                     vecs[i].exp_rom, vecs[i].exp_cs, vecs[i].exp_bank, vecs[i].exp_rd, vecs[i].exp_we);
         end
      end

      // SuperChip address passthrough
      drive(3'd1, 1'b1, 13'h107F, 1'b1, 8'h33, 1'b1);
      chk("sc_addr", 32'(bus.sc_addr_o), 32'h7F);
      chk("sc_we_top", 32'(bus.sc_we_o), 32'h1);

      // Auto mode: 16 KB image resolves to F6
      drive(3'd7, 1'b0, 13'h1000, 1'b0, 8'h00, 1'b0);
      bus.load_we_i = 1'b1;
      for (int a = 0; a < 'h4000; a++) begin
         bus.load_addr_i = RAB'(a);
         @(posedge clk);
         @(negedge clk);
      end
      bus.load_we_i = 1'b0;
      chk("auto_size16k", 32'(bus.rom_size_o), 32'h3);
      drive(3'd7, 1'b0, 13'h1FF9, 1'b0, 8'h00, 1'b1);
      chk("auto_bank", 32'(bus.bank_o), 32'h3);
      drive(3'd7, 1'b0, 13'h1000, 1'b0, 8'h00, 1'b0);
      chk("auto_rom", 32'(bus.rom_addr_o), 32'h3000);

      // Address-0 load clears the size; effective mode drops to none
      load(15'h0000);
      chk("size_clear", 32'(bus.rom_size_o), 32'h0);
      drive(3'd7, 1'b0, 13'h1000, 1'b0, 8'h00, 1'b0);
      chk("auto_none_bank", 32'(bus.bank_o), 32'h0);
      chk("auto_none_rom", 32'(bus.rom_addr_o), 32'h0000);

      // Load and hotspot on the same clock both take effect
      drive(3'd1, 1'b0, 13'h1000, 1'b0, 8'h00, 1'b0);
      bus.load_we_i = 1'b1; bus.load_addr_i = 15'h4001;
      drive(3'd1, 1'b0, 13'h1FF9, 1'b0, 8'h00, 1'b1);
      bus.load_we_i = 1'b0;
      chk("concurrent_size", 32'(bus.rom_size_o), 32'h4);
      chk("concurrent_bank", 32'(bus.bank_o), 32'h1);

      // Reset mid-load clears size; later loads keep accumulating
      load(15'h1000);
      chk("accum_size", 32'(bus.rom_size_o), 32'h5);
      bus.load_we_i = 1'b1; bus.load_addr_i = 15'h2000;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_midload_size", 32'(bus.rom_size_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.load_addr_i = 15'h1001;
      @(posedge clk); @(negedge clk);
      chk("post_rst_size", 32'(bus.rom_size_o), 32'h1);
      bus.load_addr_i = 15'h4001;
      @(posedge clk); @(negedge clk);
      bus.load_we_i = 1'b0;
      chk("odd_size", 32'(bus.rom_size_o), 32'h5);
      drive(3'd7, 1'b0, 13'h1000, 1'b0, 8'h00, 1'b0);
      drive(3'd7, 1'b0, 13'h1FF9, 1'b0, 8'h00, 1'b1);
      chk("odd_size_none_rom", 32'(bus.rom_addr_o), 32'h0FF9);
      chk("odd_size_none_bank", 32'(bus.bank_o), 32'h0);

      // Asynchronous reset restores banks without a clock edge
      drive(3'd3, 1'b0, 13'h1234, 1'b0, 8'h00, 1'b0);
      drive(3'd3, 1'b0, 13'h1FFB, 1'b0, 8'h00, 1'b1);
      chk("pre_rst_bank", 32'(bus.bank_o), 32'h7);
      bus.bus_strobe_i = 1'b0;
      bus.cpu_addr_i   = 13'h1234;
      #2 rst = 1'b1;
      #1 chk("async_rst_bank", 32'(bus.bank_o), 32'h0);
      chk("async_rst_rom", 32'(bus.rom_addr_o), 32'h0234);
      @(negedge clk);
      rst = 1'b0;
      drive(3'd3, 1'b0, 13'h1234, 1'b0, 8'h00, 1'b0);
      chk("post_rst_rom", 32'(bus.rom_addr_o), 32'h0234);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
